// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file.
package rf_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int ZERO_REG  = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue,
// cleared by writeback, with issue winning when both hit the same register.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          issue_en_i,
  input  logic [AW-1:0] issue_rd_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o
);

  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;
  logic             issue_hit_s;
  logic             wr_hit_s;

  // Next busy vector: clear the written-back register, then OR in the new
  // producer so a same-register collision leaves the bit set.
  always_comb begin
    issue_hit_s = en_i && issue_en_i && (issue_rd_i != AW'(ZERO_REG));
    wr_hit_s    = en_i && wr_en_i && (wr_addr_i != AW'(ZERO_REG));
    set_mask_s  = issue_hit_s ? (ONE_HOT0 << issue_rd_i) : {NREGS{1'b0}};
    clr_mask_s  = wr_hit_s ? (ONE_HOT0 << wr_addr_i) : {NREGS{1'b0}};
    busy_d      = (busy_q & ~clr_mask_s) | set_mask_s;
  end

  // Busy vector register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= {NREGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Busy lookup: a register being written back this cycle is reported free
  // because its value is already available through the bypass.
  always_comb begin
    rs1_busy_o = en_i && (rs1_addr_i != AW'(ZERO_REG)) && busy_q[rs1_addr_i]
                 && !(wr_en_i && (wr_addr_i == rs1_addr_i));
    rs2_busy_o = en_i && (rs2_addr_i != AW'(ZERO_REG)) && busy_q[rs2_addr_i]
                 && !(wr_en_i && (wr_addr_i == rs2_addr_i));
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: 2 read / 1 write, x0 hardwired to zero, same-cycle
// write-to-read bypass, sequential clear after reset and a pending-write
// scoreboard for decode hazard stalls.
module regfile_sb
  import rf_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            init_done
);

  rf_state_t       state_q;
  rf_state_t       state_d;
  logic [AW-1:0]   clr_cnt_q;
  logic [AW-1:0]   clr_cnt_d;
  logic            ready_s;

  logic [XLEN-1:0] mem_q [NREGS];
  logic            mem_we_s;
  logic [AW-1:0]   mem_waddr_s;
  logic [XLEN-1:0] mem_wdata_s;

  assign ready_s   = (state_q == READY);
  assign init_done = ready_s;

  // Clear FSM next state: walk every entry once, then go READY.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NREGS - 1)) begin
          state_d = READY;
        end else begin
          state_d = CLEAR;
        end
      end
      READY: begin
        state_d   = READY;
        clr_cnt_d = clr_cnt_q;
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = {AW{1'b0}};
      end
    endcase
  end

  // FSM state register; reset restarts the clear walk from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= {AW{1'b0}};
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Array write select: clear walk owns the port in CLEAR, writeback in READY.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_cnt_q;
    mem_wdata_s = {XLEN{1'b0}};
    if (rst) begin
      mem_we_s = 1'b0;
    end else if (state_q == CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_cnt_q;
      mem_wdata_s = {XLEN{1'b0}};
    end else if (wr_en && (wr_addr != AW'(ZERO_REG))) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Array storage; only the clear walk initialises it.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read ports: x0 and CLEAR read zero, a matching writeback is bypassed.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    rs2_data = {XLEN{1'b0}};
    if (ready_s && (rs1_addr != AW'(ZERO_REG))) begin
      rs1_data = (wr_en && (wr_addr == rs1_addr)) ? wr_data : mem_q[rs1_addr];
    end else begin
      rs1_data = {XLEN{1'b0}};
    end
    if (ready_s && (rs2_addr != AW'(ZERO_REG))) begin
      rs2_data = (wr_en && (wr_addr == rs2_addr)) ? wr_data : mem_q[rs2_addr];
    end else begin
      rs2_data = {XLEN{1'b0}};
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .en_i       (ready_s),
    .issue_en_i (issue_en),
    .issue_rd_i (issue_rd),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb with default parameters.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        init_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] exp1;
    logic [63:0] exp2;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t vecs [15];

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 64'd0;
    issue_en = 1'b0;
    issue_rd = 5'd0;
  endtask

  // Called right after the last rst=1 edge; checks the 32-edge clear window.
  task automatic clear_window(input logic poke);
    rst = 1'b0;
    if (poke) begin
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hBEEF;
      issue_en = 1'b1; issue_rd = 5'd5;
    end
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("clear_init_done_%0d", i), {63'd0, init_done}, 64'd0);
      chk($sformatf("clear_rs1_data_%0d", i), rs1_data, 64'd0);
      chk($sformatf("clear_rs1_busy_%0d", i), {63'd0, rs1_busy}, 64'd0);
      step();
    end
    idle();
    #1;
    chk("clear_done", {63'd0, init_done}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    idle();

    // reset state
    step();
    chk("rst_init_done", {63'd0, init_done}, 64'd0);
    chk("rst_rs1_data", rs1_data, 64'd0);
    chk("rst_rs2_data", rs2_data, 64'd0);
    chk("rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    chk("rst_rs2_busy", {63'd0, rs2_busy}, 64'd0);

    // clear timing with writes/issues poked during CLEAR
    clear_window(1'b1);
    for (int r = 0; r < 32; r++) begin
      rs1_addr = 5'(r);
      rs2_addr = 5'(31 - r);
      #1;
      chk($sformatf("cleared_rs1_x%0d", r), rs1_data, 64'd0);
      chk($sformatf("cleared_rs2_x%0d", 31 - r), rs2_data, 64'd0);
      chk($sformatf("cleared_busy_x%0d", r), {63'd0, rs1_busy}, 64'd0);
    end

    // reset mid-clear after x5 holds 0xDEAD
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD;
    step();
    idle();
    rs1_addr = 5'd5;
    #1;
    chk("x5_written", rs1_data, 64'hDEAD);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    clear_window(1'b0);
    rs1_addr = 5'd5;
    #1;
    chk("x5_after_restart", rs1_data, 64'd0);

    // table of READY-state vectors, checked before each edge
    vecs[0]  = '{1'b1, 5'd1, 64'h11,   1'b0, 5'd0, 5'd1, 5'd2, 64'h11,   64'h0,    1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd2, 64'h22,   1'b0, 5'd0, 5'd1, 5'd2, 64'h11,   64'h22,   1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd9, 5'd9, 5'd1, 64'h0,    64'h11,   1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd9, 5'd2, 64'h0,    64'h22,   1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'd9, 64'hABC,  1'b0, 5'd0, 5'd9, 5'd9, 64'hABC,  64'hABC,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd9, 5'd0, 64'hABC,  64'h0,    1'b0, 1'b0};
    vecs[6]  = '{1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd0, 5'd1, 64'h0,    64'h11,   1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 5'd7, 5'd7, 64'h1234, 64'h1234, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd7, 5'd0, 64'h1234, 64'h0,    1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd3, 5'd3, 5'd0, 64'h0,    64'h0,    1'b0, 1'b0};
    vecs[11] = '{1'b1, 5'd3, 64'h3333, 1'b1, 5'd3, 5'd3, 5'd3, 64'h3333, 64'h3333, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd3, 5'd0, 64'h3333, 64'h0,    1'b1, 1'b0};
    vecs[13] = '{1'b1, 5'd3, 64'h4444, 1'b1, 5'd5, 5'd3, 5'd5, 64'h4444, 64'h0,    1'b0, 1'b0};
    vecs[14] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd3, 5'd5, 64'h4444, 64'h0,    1'b0, 1'b1};

    for (int v = 0; v < 15; v++) begin
      wr_en    = vecs[v].wr_en;
      wr_addr  = vecs[v].wr_addr;
      wr_data  = vecs[v].wr_data;
      issue_en = vecs[v].issue_en;
      issue_rd = vecs[v].issue_rd;
      rs1_addr = vecs[v].rs1;
      rs2_addr = vecs[v].rs2;
      #1;
      chk($sformatf("v%0d_rs1_data", v), rs1_data, vecs[v].exp1);
      chk($sformatf("v%0d_rs2_data", v), rs2_data, vecs[v].exp2);
      chk($sformatf("v%0d_rs1_busy", v), {63'd0, rs1_busy}, {63'd0, vecs[v].eb1});
      chk($sformatf("v%0d_rs2_busy", v), {63'd0, rs2_busy}, {63'd0, vecs[v].eb2});
      chk($sformatf("v%0d_init_done", v), {63'd0, init_done}, 64'd1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the RISC-V datapath. It is the successor to the current 2-read/1-write register array. New features:
- x0 hardwired to zero.
- Write-to-read bypass.
- Synchronous reset that clears the array through a sequential clear sequence.
- Per-register pending-write scoreboard, used by the decode stage for hazard stalls.

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREGS), register address width (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
rs1_busy  output  1  pending write outstanding on rs1_addr
rs2_busy  output  1  pending write outstanding on rs2_addr
wr_en  input  1  writeback enable (RegWrite)
wr_addr  input  AW  writeback destination
wr_data  input  XLEN  writeback data
issue_en  input  1  instruction with destination issued this cycle
issue_rd  input  AW  destination register of the issued instruction
init_done  output  1  high once the clear sequence has finished

Behaviour:
- The clock is clk; reset is rst, synchronous and active-high. No asynchronous state.
- FSM states: CLEAR and READY.
  - rst=1 at an edge: state<=CLEAR, clr_cnt<=0, all busy bits<=0.
  - CLEAR: each edge writes 0 to reg[clr_cnt] and increments clr_cnt. At clr_cnt==NREGS-1, the write occurs and state<=READY.
  - rst deasserted at edge k: init_done rises after edge k+NREGS (32 cycles by default).
  - rst reasserted mid-clear restarts at clr_cnt=0.
- During CLEAR:
  - init_done=0.
  - rs1_data and rs2_data read 0; rs1_busy and rs2_busy read 0.
  - wr_en and issue_en are ignored; no array or scoreboard update.
- During READY: init_done=1.
- Reset values of outputs: init_done=0, rs*_data=0, rs*_busy=0.
- Register x0:
  - Reads of address 0 always return 0.
  - Writes to address 0 are dropped.
  - issue_rd==0 never sets a busy bit.
- Write (READY, wr_en=1, wr_addr!=0): reg[wr_addr]<=wr_data at the edge.
- Read: rsN_data = (wr_en && wr_addr==rsN_addr && rsN_addr!=0 && READY) ? wr_data : reg[rsN_addr]. This gives same-cycle bypass with zero-cycle read latency. Both ports may hit the bypass simultaneously.
- Scoreboard: busy[NREGS] bits.
  - issue_en && issue_rd!=0 sets busy[issue_rd].
  - wr_en && wr_addr!=0 clears busy[wr_addr].
  - Same edge, same register, both issue and write: set wins and busy stays 1 (new producer).
  - Different registers: both take effect.
- rsN_busy = busy[rsN_addr] && !(wr_en && wr_addr==rsN_addr). The register being written back this cycle is reported not busy because its data is bypassed. rsN_busy is 0 for address 0.
- Issue to a register that is already busy is legal. busy stays 1 and is cleared by the next writeback to it. Decode is responsible for not issuing WAW while busy.
- Array contents have no per-entry reset other than the CLEAR sequence.

Decomposition:
- Package rf_pkg holds:
  - XLEN, NREGS and AW defaults.
  - ZERO_REG constant (0).
  - State enum rf_state_t {CLEAR, READY}.
- One sub-module: rf_scoreboard. It contains the busy vector, set/clear priority and busy lookup for two read addresses. It has its own clk, rst and an enable tied to READY.
- Array storage, bypass and the clear FSM stay in regfile_sb.

Test Plan:
- Reset then clear timing: pulse rst for 1 cycle.
  - init_done=0 for exactly 32 edges, then 1.
  - All 32 registers read 0.
  - A wr_en presented during CLEAR leaves no trace.
- Reset mid-clear: reassert rst at clr_cnt=10 after x5 was earlier written 0xDEAD. Required: full 32-cycle restart, and x5 reads 0 afterwards.
- x0 protection: write 0xFFFF_FFFF_FFFF_FFFF to x0 with issue_rd=0. Required: rs1_data=0 and rs1_busy=0 on all subsequent cycles.
- Bypass: same cycle, wr_en=1, wr_addr=7, wr_data=0x1234, rs1_addr=rs2_addr=7. Required: both ports read 0x1234 that cycle, and reg[7]=0x1234 on the next cycle.
- Scoreboard: issue_rd=9 at edge n. Required: rs1_busy=1 for rs1_addr=9 from n+1. Then wr_en to x9: busy reads 0 in the writeback cycle and stays 0 after.
- Set-wins collision: issue_rd=3 and wr_addr=3 on the same edge while x3 is busy. Required: rs1_busy(3)=1 afterwards and x3 holds the written value.
